// File: rtl/tl_defs.sv
// rtl/tl_defs.sv - shared phase, mode and lamp codes for the intersection controller
package tl_defs;

  typedef enum logic [3:0] {
    S_NS_GREEN  = 4'd0,
    S_NS_YELLOW = 4'd1,
    S_NS_ALLRED = 4'd2,
    S_EW_GREEN  = 4'd3,
    S_EW_YELLOW = 4'd4,
    S_EW_ALLRED = 4'd5,
    S_FLASH     = 4'd6,
    S_ALL_RED   = 4'd7
  } phase_t;

  typedef enum logic [1:0] {
    MODE_FIXED  = 2'b00,
    MODE_ACT    = 2'b01,
    MODE_FLASH  = 2'b10,
    MODE_ALLRED = 2'b11
  } mode_t;

  // Lamp drives are {R,Y,G}
  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b100;

  function automatic logic is_green(input phase_t p);
    return (p == S_NS_GREEN) || (p == S_EW_GREEN);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase tick counter with clear, saturating increment and done compare
module phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] sat_max,
  input  logic [7:0] dur,
  output logic [7:0] tmr,
  output logic       done
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (inc && (cnt < sat_max)) begin
      cnt <= cnt + 8'd1;
    end
  end

  // >= rather than == so a mid-phase mode change that leaves cnt past the
  // limit still terminates instead of stalling
  assign done = (cnt >= (dur - 8'd1));
  assign tmr  = cnt;

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - NS/EW signal phase FSM with fixed, actuated, flash and all-red modes
module phase_sequencer
  import tl_defs::*;
#(
  parameter int T_FIXED_GREEN = 20,
  parameter int T_MIN_GREEN   = 10,
  parameter int T_MAX_GREEN   = 30,
  parameter int T_YELLOW      = 3,
  parameter int T_ALLRED      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [1:0] mode_sel,
  input  logic       veh_NS,
  input  logic       veh_EW,
  output logic [3:0] phase_id,
  output logic [2:0] ns_rgy,
  output logic [2:0] ew_rgy,
  output logic [7:0] time_left,
  output logic       phase_start
);

  localparam logic [7:0] TF   = 8'(T_FIXED_GREEN);
  localparam logic [7:0] TMIN = 8'(T_MIN_GREEN);
  localparam logic [7:0] TMAX = 8'(T_MAX_GREEN);
  localparam logic [7:0] TY   = 8'(T_YELLOW);
  localparam logic [7:0] TA   = 8'(T_ALLRED);

  phase_t     phase_q, phase_d;
  mode_t      mode;
  logic       start_q, blink_q, changed;
  logic       own_dem, opp_dem, go_green_end;
  logic [7:0] tmr, dur, sat_max, green_left;
  logic       done;

  assign mode    = mode_t'(mode_sel);
  assign changed = (phase_d != phase_q);

  phase_timer u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (changed),
    .inc     (tick),
    .sat_max (sat_max),
    .dur     (dur),
    .tmr     (tmr),
    .done    (done)
  );

  // Actuated green saturates at max so it can rest without wrapping
  always_comb begin
    dur     = TA;
    sat_max = 8'hFF;
    if (is_green(phase_q)) begin
      if (mode == MODE_ACT) begin
        dur     = TMAX;
        sat_max = TMAX - 8'd1;
      end else begin
        dur = TF;
      end
    end else if ((phase_q == S_NS_YELLOW) || (phase_q == S_EW_YELLOW)) begin
      dur = TY;
    end
  end

  always_comb begin
    own_dem = (phase_q == S_NS_GREEN) ? veh_NS : veh_EW;
    opp_dem = (phase_q == S_NS_GREEN) ? veh_EW : veh_NS;
    case (mode)
      MODE_FIXED: go_green_end = done;
      MODE_ACT:   go_green_end = (tmr >= (TMIN - 8'd1)) && opp_dem && (!own_dem || done);
      default:    go_green_end = 1'b1;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      S_NS_GREEN:  if (tick && go_green_end) phase_d = S_NS_YELLOW;
      S_EW_GREEN:  if (tick && go_green_end) phase_d = S_EW_YELLOW;
      S_NS_YELLOW: if (tick && done) phase_d = S_NS_ALLRED;
      S_EW_YELLOW: if (tick && done) phase_d = S_EW_ALLRED;
      S_NS_ALLRED, S_EW_ALLRED: begin
        if (tick && done) begin
          case (mode)
            MODE_FLASH:  phase_d = S_FLASH;
            MODE_ALLRED: phase_d = S_ALL_RED;
            default:     phase_d = (phase_q == S_NS_ALLRED) ? S_EW_GREEN : S_NS_GREEN;
          endcase
        end
      end
      S_FLASH: begin
        if (tick) begin
          if (mode == MODE_ALLRED) phase_d = S_ALL_RED;
          else if (mode != MODE_FLASH) phase_d = S_EW_ALLRED;
        end
      end
      S_ALL_RED: begin
        if (tick) begin
          if (mode == MODE_FLASH) phase_d = S_FLASH;
          else if (mode != MODE_ALLRED) phase_d = S_EW_ALLRED;
        end
      end
      default: phase_d = S_EW_ALLRED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= S_EW_ALLRED;
      start_q <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      start_q <= changed;
      if (changed && (phase_d == S_FLASH)) blink_q <= 1'b0;
      else if (tick) blink_q <= ~blink_q;
    end
  end

  always_comb begin
    if (mode == MODE_ACT) green_left = (tmr >= (TMAX - 8'd1)) ? 8'd1 : (TMAX - tmr);
    else                  green_left = (tmr >= TF) ? 8'd1 : (TF - tmr);
  end

  always_comb begin
    ns_rgy    = LAMP_R;
    ew_rgy    = LAMP_R;
    time_left = 8'd0;
    case (phase_q)
      S_NS_GREEN: begin
        ns_rgy    = LAMP_G;
        time_left = green_left;
      end
      S_NS_YELLOW: begin
        ns_rgy    = LAMP_Y;
        time_left = TY - tmr;
      end
      S_EW_GREEN: begin
        ew_rgy    = LAMP_G;
        time_left = green_left;
      end
      S_EW_YELLOW: begin
        ew_rgy    = LAMP_Y;
        time_left = TY - tmr;
      end
      S_NS_ALLRED, S_EW_ALLRED: time_left = TA - tmr;
      S_FLASH: begin
        ns_rgy = blink_q ? LAMP_Y : LAMP_OFF;
        ew_rgy = blink_q ? LAMP_Y : LAMP_OFF;
      end
      default: time_left = 8'd0;
    endcase
  end

  assign phase_id    = phase_q;
  assign phase_start = start_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - randomized, model-checked bench for phase_sequencer
module tb_phase_sequencer;

  localparam int TF = 5, TMIN = 4, TMAX = 8, TY = 2, TA = 1;

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic [1:0] mode_sel = 2'b00;
  logic       veh_NS = 1'b0, veh_EW = 1'b0;
  logic [3:0] phase_id;
  logic [2:0] ns_rgy, ew_rgy;
  logic [7:0] time_left;
  logic       phase_start;

  int checks = 0, failures = 0;
  int m_phase, m_el;
  bit m_blink, m_chg;

  phase_sequencer #(
    .T_FIXED_GREEN (TF),
    .T_MIN_GREEN   (TMIN),
    .T_MAX_GREEN   (TMAX),
    .T_YELLOW      (TY),
    .T_ALLRED      (TA)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .mode_sel    (mode_sel),
    .veh_NS      (veh_NS),
    .veh_EW      (veh_EW),
    .phase_id    (phase_id),
    .ns_rgy      (ns_rgy),
    .ew_rgy      (ew_rgy),
    .time_left   (time_left),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] exp_tl();
    int r;
    case (m_phase)
      0, 3: begin
        if (mode_sel == 2'b01) r = (TMAX - m_el < 1) ? 1 : TMAX - m_el;
        else r = (m_el >= TF) ? 1 : TF - m_el;
      end
      1, 4: r = TY - m_el;
      2, 5: r = TA - m_el;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  function automatic logic [5:0] exp_lamps();
    case (m_phase)
      0: return 6'b001_100;
      1: return 6'b010_100;
      3: return 6'b100_001;
      4: return 6'b100_010;
      6: return m_blink ? 6'b010_010 : 6'b000_000;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic model_step(input bit vns, input bit vew);
    int nxt;
    bit own, opp, fin;
    nxt = m_phase;
    case (m_phase)
      0, 3: begin
        own = (m_phase == 0) ? vns : vew;
        opp = (m_phase == 0) ? vew : vns;
        case (mode_sel)
          2'b00:   fin = (m_el >= TF - 1);
          2'b01:   fin = (m_el >= TMIN - 1) && opp && (!own || m_el >= TMAX - 1);
          default: fin = 1'b1;
        endcase
        if (fin) nxt = m_phase + 1;
      end
      1, 4: if (m_el >= TY - 1) nxt = m_phase + 1;
      2, 5: if (m_el >= TA - 1) nxt = (mode_sel == 2) ? 6 : (mode_sel == 3) ? 7 : (m_phase == 2) ? 3 : 0;
      6: if (mode_sel == 3) nxt = 7; else if (mode_sel < 2) nxt = 5;
      7: if (mode_sel == 2) nxt = 6; else if (mode_sel < 2) nxt = 5;
      default: nxt = 5;
    endcase
    m_chg = (nxt != m_phase);
    if (m_chg) begin
      m_el = 0;
      if (nxt == 6) m_blink = 1'b0;
    end else begin
      if (m_phase == 6) m_blink = ~m_blink;
      if (!((m_phase == 0 || m_phase == 3) && mode_sel == 2'b01 && m_el >= TMAX - 1)) m_el++;
    end
    m_phase = nxt;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input bit nt, input bit et, input bit nb, input bit eb);
    veh_NS = nt;
    veh_EW = et;
    tick   = 1'b1;
    @(posedge clk);
    #1;
    tick   = 1'b0;
    veh_NS = nb;
    veh_EW = eb;
    model_step(nt, et);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tick   = 1'b0;
    veh_NS = 1'b0;
    veh_EW = 1'b0;
    idle(2);
    rst_n   = 1'b1;
    m_phase = 5;
    m_el    = 0;
    m_blink = 1'b0;
    m_chg   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {4'd5, 3'b100, 3'b100, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got ph=%0d ns=%b ew=%b tl=%0d ps=%b want ph=5 ns=100 ew=100 tl=1 ps=0",
               phase_id, ns_rgy, ew_rgy, time_left, phase_start);
    end
  endtask

  task automatic test_fixed();
    int exp_ph[7]  = '{5, 0, 1, 2, 3, 4, 5};
    int exp_dur[7] = '{1, 5, 2, 1, 5, 2, 1};
    int cur, len, idx;
    do_reset();
    mode_sel = 2'b00;
    cur = 5; len = 0; idx = 0;
    for (int t = 0; t < 18; t++) begin
      do_tick(0, 0, 0, 0);
      len++;
      checks++;
      if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {m_phase[3:0], exp_lamps(), exp_tl(), m_chg}) begin
        failures++;
        $display("FAIL fixed_tick%0d got ph=%0d ns=%b ew=%b tl=%0d ps=%b want ph=%0d lamps=%b tl=%0d ps=%b",
                 t, phase_id, ns_rgy, ew_rgy, time_left, phase_start, m_phase, exp_lamps(), exp_tl(), m_chg);
      end
      if (int'(phase_id) != cur && idx < 7) begin
        checks++;
        if (cur != exp_ph[idx] || len != exp_dur[idx]) begin
          failures++;
          $display("FAIL fixed_seq%0d got phase %0d for %0d ticks want phase %0d for %0d ticks",
                   idx, cur, len, exp_ph[idx], exp_dur[idx]);
        end
        idx++;
        cur = int'(phase_id);
        len = 0;
      end
      idle(1);
      checks++;
      if (phase_start !== 1'b0) begin
        failures++;
        $display("FAIL fixed_start_width%0d got phase_start=%b want 0", t, phase_start);
      end
      idle(2);
    end
    checks++;
    if (idx != 7) begin
      failures++;
      $display("FAIL fixed_seq_count got %0d phase changes want 7", idx);
    end
  endtask

  task automatic test_act_ew_only();
    int cnt;
    do_reset();
    mode_sel = 2'b01;
    do_tick(0, 1, 0, 1);
    idle(3);
    cnt = 0;
    while (phase_id == 4'd0 && cnt < 20) begin
      do_tick(0, 1, 0, 1);
      cnt++;
      checks++;
      if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {m_phase[3:0], exp_lamps(), exp_tl(), m_chg}) begin
        failures++;
        $display("FAIL act_ns_tick%0d got ph=%0d tl=%0d ps=%b want ph=%0d tl=%0d ps=%b",
                 cnt, phase_id, time_left, phase_start, m_phase, exp_tl(), m_chg);
      end
      idle(3);
    end
    checks++;
    if (cnt != 4) begin
      failures++;
      $display("FAIL act_min_green got %0d ticks want 4", cnt);
    end
    for (int t = 0; t < 27; t++) begin
      do_tick(0, 0, 0, 0);
      checks++;
      if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {m_phase[3:0], exp_lamps(), exp_tl(), m_chg}) begin
        failures++;
        $display("FAIL act_rest_tick%0d got ph=%0d tl=%0d ps=%b want ph=%0d tl=%0d ps=%b",
                 t, phase_id, time_left, phase_start, m_phase, exp_tl(), m_chg);
      end
      idle(3);
    end
    checks++;
    if (phase_id !== 4'd3 || time_left !== 8'd1) begin
      failures++;
      $display("FAIL act_rest_hold got ph=%0d tl=%0d want ph=3 tl=1", phase_id, time_left);
    end
  endtask

  task automatic test_maxout();
    int cnt;
    do_reset();
    mode_sel = 2'b01;
    do_tick(1, 1, 1, 1);
    idle(3);
    for (int g = 0; g < 2; g++) begin
      cnt = 0;
      while ((phase_id == 4'd0 || phase_id == 4'd3) && cnt < 20) begin
        checks++;
        if (time_left !== 8'(TMAX - cnt)) begin
          failures++;
          $display("FAIL maxout_tl g%0d k%0d got %0d want %0d", g, cnt, time_left, TMAX - cnt);
        end
        do_tick(1, 1, 1, 1);
        cnt++;
        idle(3);
      end
      checks++;
      if (cnt != TMAX) begin
        failures++;
        $display("FAIL maxout_len g%0d got %0d ticks want %0d", g, cnt, TMAX);
      end
      repeat (3) begin
        do_tick(1, 1, 1, 1);
        idle(3);
      end
      checks++;
      if ({phase_id, time_left} !== {m_phase[3:0], exp_tl()}) begin
        failures++;
        $display("FAIL maxout_next g%0d got ph=%0d tl=%0d want ph=%0d tl=%0d", g, phase_id, time_left, m_phase, exp_tl());
      end
    end
  endtask

  task automatic test_pulse_between();
    do_reset();
    mode_sel = 2'b01;
    do_tick(0, 0, 0, 1);
    idle(3);
    for (int t = 0; t < 20; t++) begin
      do_tick(0, 0, 0, 1);
      checks++;
      if (phase_id !== 4'd0 || {phase_id, time_left} !== {m_phase[3:0], exp_tl()}) begin
        failures++;
        $display("FAIL pulse_between_tick%0d got ph=%0d tl=%0d want ph=0 tl=%0d", t, phase_id, time_left, exp_tl());
      end
      idle(3);
    end
  endtask

  task automatic test_flash();
    int exp_seq[9] = '{1, 1, 2, 6, 6, 6, 6, 5, 0};
    do_reset();
    mode_sel = 2'b00;
    do_tick(0, 0, 0, 0);
    idle(3);
    do_tick(0, 0, 0, 0);
    idle(3);
    mode_sel = 2'b10;
    for (int t = 0; t < 9; t++) begin
      if (t == 7) mode_sel = 2'b00;
      do_tick(0, 0, 0, 0);
      checks++;
      if (int'(phase_id) != exp_seq[t] ||
          {phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {m_phase[3:0], exp_lamps(), exp_tl(), m_chg}) begin
        failures++;
        $display("FAIL flash_step%0d got ph=%0d ns=%b ew=%b tl=%0d ps=%b want ph=%0d lamps=%b tl=%0d ps=%b",
                 t, phase_id, ns_rgy, ew_rgy, time_left, phase_start, exp_seq[t], exp_lamps(), exp_tl(), m_chg);
      end
      idle(3);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    mode_sel = 2'b00;
    n = 0;
    while (m_phase != 4 && n < 20) begin
      do_tick(0, 0, 0, 0);
      idle(3);
      n++;
    end
    checks++;
    if (phase_id !== 4'd4) begin
      failures++;
      $display("FAIL async_reach_ew_yellow got ph=%0d want 4", phase_id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {4'd5, 3'b100, 3'b100, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_values got ph=%0d ns=%b ew=%b tl=%0d ps=%b want ph=5 ns=100 ew=100 tl=1 ps=0",
               phase_id, ns_rgy, ew_rgy, time_left, phase_start);
    end
    do_reset();
    for (int t = 0; t < 9; t++) begin
      do_tick(0, 0, 0, 0);
      checks++;
      if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {m_phase[3:0], exp_lamps(), exp_tl(), m_chg}) begin
        failures++;
        $display("FAIL async_restart_tick%0d got ph=%0d tl=%0d ps=%b want ph=%0d tl=%0d ps=%b",
                 t, phase_id, time_left, phase_start, m_phase, exp_tl(), m_chg);
      end
      idle(3);
    end
  endtask

  task automatic test_random();
    int r;
    bit nt, et;
    do_reset();
    mode_sel = 2'b00;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 9);
        mode_sel = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      end
      nt = 1'($urandom_range(0, 1));
      et = 1'($urandom_range(0, 1));
      do_tick(nt, et, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if ({phase_id, ns_rgy, ew_rgy, time_left, phase_start} !== {m_phase[3:0], exp_lamps(), exp_tl(), m_chg}) begin
        failures++;
        $display("FAIL random_tick%0d mode=%0d got ph=%0d ns=%b ew=%b tl=%0d ps=%b want ph=%0d lamps=%b tl=%0d ps=%b",
                 t, mode_sel, phase_id, ns_rgy, ew_rgy, time_left, phase_start, m_phase, exp_lamps(), exp_tl(), m_chg);
      end
      checks++;
      if (phase_id != 4'd6 && (ns_rgy[1:0] != 2'b00) && (ew_rgy[1:0] != 2'b00)) begin
        failures++;
        $display("FAIL lamp_safety_tick%0d got ns=%b ew=%b want at most one approach green/yellow", t, ns_rgy, ew_rgy);
      end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fixed();
    test_act_ew_only();
    test_maxout();
    test_pulse_between();
    test_flash();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
